mac_channel_feeder: RTL and testbench

- Initiator side of the mac_array channel-sequenced interface.
- Collects one 3x3 feature window plus kernel per input channel from the line-buffer/weight path, using a per-channel valid/ready handshake.
- Bursts all channels into mac_array on back-to-back cycles, with start asserted on channel 0.
- Waits for done, captures mac_output, and returns the pixel result downstream over valid/ready.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/channel_window_bank.sv | 40 ++++
 rtl/mac_channel_feeder.sv | 160 ++++++++++++++++
 tb/tb_mac_channel_feeder.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_array feeder path.
package mac_pkg;

  localparam int MAC_DATA_WIDTH  = 16;
  localparam int MAC_KERNEL_SIZE = 3;

  // Q2.14 fixed point: 14 fractional bits, same scaling as mac_array.
  localparam int FRAC_SZ = 14;

  // One signed KxK window (or kernel) of Q2.14 samples.
  typedef logic signed [MAC_KERNEL_SIZE-1:0][MAC_KERNEL_SIZE-1:0][MAC_DATA_WIDTH-1:0] win_t;

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    BURST     = 2'd1,
    WAIT_DONE = 2'd2,
    OUTPUT    = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/channel_window_bank.sv
// Per-channel storage of window+kernel pairs. One write port fills the bank
// while collecting, one read port replays it during the burst.
module channel_window_bank
  import mac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 144,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_win_i,
  input  logic [WIDTH-1:0] wr_ker_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_win_o,
  output logic [WIDTH-1:0] rd_ker_o
);

  logic [WIDTH-1:0] win_q [DEPTH];
  logic [WIDTH-1:0] ker_q [DEPTH];

  // Write the accepted channel pair; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        win_q[i] <= '0;
        ker_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      win_q[wr_addr_i] <= wr_win_i;
      ker_q[wr_addr_i] <= wr_ker_i;
    end
  end

  assign rd_win_o = win_q[rd_addr_i];
  assign rd_ker_o = ker_q[rd_addr_i];

endmodule

// File: rtl/mac_channel_feeder.sv
// Initiator side of the mac_array channel-sequenced interface: collect one
// window+kernel per channel, burst them gap-free with start on channel 0,
// wait for done (with watchdog), then hand the pixel result downstream.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; the sender holds its data stable while valid && !ready.
module mac_channel_feeder
  import mac_pkg::*;
#(
  parameter int IN_CHANNELS  = 4,
  parameter int KERNEL_SIZE  = MAC_KERNEL_SIZE,
  parameter int DATA_WIDTH   = MAC_DATA_WIDTH,
  parameter int DONE_TIMEOUT = 64,
  localparam int WIN_W       = DATA_WIDTH * KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ch_valid,
  output logic                  ch_ready,
  input  logic [WIN_W-1:0]      ch_window,
  input  logic [WIN_W-1:0]      ch_kernel,
  input  logic [DATA_WIDTH-1:0] ch_col_index,
  output logic                  mac_start,
  output logic [WIN_W-1:0]      mac_feature_map,
  output logic [WIN_W-1:0]      mac_kernel,
  output logic [DATA_WIDTH-1:0] mac_col_index,
  input  logic [DATA_WIDTH-1:0] mac_output,
  input  logic                  mac_done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [DATA_WIDTH-1:0] res_col_index,
  output logic                  err_timeout
);

  localparam int CNT_W = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int WD_W  = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(IN_CHANNELS - 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(DONE_TIMEOUT);

  feeder_state_e         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [DATA_WIDTH-1:0] col_q, col_d;
  logic                  ch_ready_q;
  logic [WIN_W-1:0]      fm_hold_q, kn_hold_q;
  logic [DATA_WIDTH-1:0] res_data_q, res_col_q;
  logic [WIN_W-1:0]      rd_win, rd_ker;
  logic                  accept;
  logic                  cap_result;

  assign accept = ch_valid && ch_ready_q && (state_q == COLLECT);

  // The same counter indexes the bank for writes (collect) and reads (burst).
  channel_window_bank #(
    .DEPTH (IN_CHANNELS),
    .WIDTH (WIN_W),
    .AW    (CNT_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_addr_i (cnt_q),
    .wr_win_i  (ch_window),
    .wr_ker_i  (ch_kernel),
    .rd_addr_i (cnt_q),
    .rd_win_o  (rd_win),
    .rd_ker_o  (rd_ker)
  );

  // Next-state, counters, watchdog and per-state strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    col_d       = col_q;
    mac_start   = 1'b0;
    err_timeout = 1'b0;
    res_valid   = 1'b0;
    cap_result  = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q == '0) col_d = ch_col_index;
          if (cnt_q == LAST_CH) begin
            cnt_d   = '0;
            state_d = BURST;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      BURST: begin
        mac_start = (cnt_q == '0);
        wd_d      = '0;
        if (cnt_q == LAST_CH) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (mac_done) begin
          cap_result = 1'b1;
          state_d    = OUTPUT;
        end else if (wd_q == WD_MAX) begin
          err_timeout = 1'b1;
          state_d     = COLLECT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // State register plus held datapath values; reset aborts any tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      wd_q       <= '0;
      col_q      <= '0;
      ch_ready_q <= 1'b0;
      fm_hold_q  <= '0;
      kn_hold_q  <= '0;
      res_data_q <= '0;
      res_col_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      col_q      <= col_d;
      ch_ready_q <= (state_d == COLLECT);
      if (state_q == BURST) begin
        fm_hold_q <= rd_win;
        kn_hold_q <= rd_ker;
      end
      if (cap_result) begin
        res_data_q <= mac_output;
        res_col_q  <= col_q;
      end
    end
  end

  // The bank drives mac_array live during the burst; otherwise the last
  // burst value is held so the bus does not toggle between tiles.
  assign mac_feature_map = (state_q == BURST) ? rd_win : fm_hold_q;
  assign mac_kernel      = (state_q == BURST) ? rd_ker : kn_hold_q;
  assign mac_col_index   = col_q;
  assign ch_ready        = ch_ready_q;
  assign res_data        = res_data_q;
  assign res_col_index   = res_col_q;

endmodule

// File: tb/tb_mac_channel_feeder.sv
// Bench for mac_channel_feeder with a behavioural mac_array responder.
module tb_mac_channel_feeder;

  localparam int NCH   = 4;
  localparam int K     = 3;
  localparam int DW    = 16;
  localparam int WIN_W = DW * K * K;
  localparam int FRAC  = 14;

  typedef logic [WIN_W-1:0] tile_t [NCH];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic             ch_valid, ch_ready;
  logic [WIN_W-1:0] ch_window, ch_kernel;
  logic [DW-1:0]    ch_col_index;
  logic             mac_start;
  logic [WIN_W-1:0] mac_feature_map, mac_kernel;
  logic [DW-1:0]    mac_col_index, mac_output;
  logic             mac_done, mac_done_m, spur_done;
  logic             res_valid, res_ready;
  logic [DW-1:0]    res_data, res_col_index;
  logic             err_timeout;

  assign mac_done = mac_done_m | spur_done;

  mac_channel_feeder #(
    .IN_CHANNELS (NCH), .KERNEL_SIZE (K), .DATA_WIDTH (DW), .DONE_TIMEOUT (64)
  ) dut (
    .clk (clk), .rst (rst),
    .ch_valid (ch_valid), .ch_ready (ch_ready),
    .ch_window (ch_window), .ch_kernel (ch_kernel), .ch_col_index (ch_col_index),
    .mac_start (mac_start), .mac_feature_map (mac_feature_map),
    .mac_kernel (mac_kernel), .mac_col_index (mac_col_index),
    .mac_output (mac_output), .mac_done (mac_done),
    .res_valid (res_valid), .res_ready (res_ready),
    .res_data (res_data), .res_col_index (res_col_index),
    .err_timeout (err_timeout)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];           // {col_index, pixel}
  tile_t       tile_win, tile_ker;
  logic [DW-1:0] tile_col;
  logic [DW-1:0] last_res;

  // mac_array model state
  tile_t         obs_win, obs_ker;
  logic [DW-1:0] obs_col;
  int start_cnt = 0, extra_start = 0;
  int burst_end_cyc = 0, done_cyc = 0;
  int mac_lat = 3;
  bit mac_respond = 1'b1;

  // Pixel = saturate16( sum over channels of (dot(window,kernel) >>> 14) ).
  function automatic logic [DW-1:0] ref_pixel(input tile_t w, input tile_t k);
    longint acc, s;
    acc = 0;
    for (int c = 0; c < NCH; c++) begin
      s = 0;
      for (int i = 0; i < K * K; i++)
        s += longint'($signed(w[c][i*DW +: DW])) * longint'($signed(k[c][i*DW +: DW]));
      acc += (s >>> FRAC);
    end
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[DW-1:0];
  endfunction

  function automatic logic [WIN_W-1:0] rep9(input logic [DW-1:0] v);
    logic [WIN_W-1:0] r;
    for (int i = 0; i < K * K; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  // Behavioural mac_array: captures the burst starting at mac_start and
  // answers with a one-cycle done after mac_lat cycles.
  initial begin
    mac_done_m = 1'b0;
    mac_output = '0;
    forever begin
      @(negedge clk);
      mac_done_m = 1'b0;
      if (mac_start === 1'b1 && rst === 1'b0) begin
        start_cnt++;
        obs_col    = mac_col_index;
        obs_win[0] = mac_feature_map;
        obs_ker[0] = mac_kernel;
        for (int k = 1; k < NCH; k++) begin
          @(negedge clk);
          if (mac_start === 1'b1) extra_start++;
          obs_win[k] = mac_feature_map;
          obs_ker[k] = mac_kernel;
        end
        burst_end_cyc = cyc;
        if (mac_respond) begin
          repeat (mac_lat) @(negedge clk);
          mac_output = ref_pixel(obs_win, obs_ker);
          mac_done_m = 1'b1;
          done_cyc   = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_tile(input int gap_mode);
    int n, gap;
    for (int c = 0; c < NCH; c++) begin
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      ch_valid = 1'b0;
      repeat (gap) @(negedge clk);
      ch_valid     = 1'b1;
      ch_window    = tile_win[c];
      ch_kernel    = tile_ker[c];
      ch_col_index = (c == 0) ? tile_col : DW'($urandom);
      n = 0;
      while (ch_ready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 200) begin
        errors++;
        $display("FAIL ch_accept: ch_ready=%b for channel %0d after %0d cycles, required 1", ch_ready, c, n);
        ch_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ch_valid  = 1'b0;
    ch_window = {WIN_W{1'b1}};
    ch_kernel = {WIN_W{1'b1}};
    checks++;
    if (mac_start !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: mac_start=%b one cycle after last accept, required 1", mac_start);
    end
  endtask

  task automatic push_expected();
    exp_q.push_back({tile_col, ref_pixel(tile_win, tile_ker)});
  endtask

  task automatic recv_result(input int stall);
    int n;
    logic [31:0] exp;
    logic [DW-1:0] d0, c0;
    n = 0;
    while (res_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL res_wait: res_valid=%b after %0d cycles, required 1", res_valid, n);
      return;
    end
    checks++;
    if (cyc != done_cyc + 1) begin
      errors++;
      $display("FAIL done_to_valid: res_valid at cycle %0d, required %0d", cyc, done_cyc + 1);
    end
    d0 = res_data;
    c0 = res_col_index;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== d0 || res_col_index !== c0 || ch_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: valid=%b data=%h col=%h ch_ready=%b, required 1 %h %h 0",
                 res_valid, res_data, res_col_index, ch_ready, d0, c0);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: result %h arrived with empty expected queue, required none", d0);
    end else begin
      exp = exp_q.pop_front();
      if (d0 !== exp[DW-1:0] || c0 !== exp[2*DW-1:DW]) begin
        errors++;
        $display("FAIL res_value: data=%h col=%h, required data=%h col=%h",
                 d0, c0, exp[DW-1:0], exp[2*DW-1:DW]);
      end
    end
    checks++;
    if (res_valid !== 1'b0 || ch_ready !== 1'b1) begin
      errors++;
      $display("FAIL handoff: res_valid=%b ch_ready=%b after accept, required 0 1", res_valid, ch_ready);
    end
    last_res = d0;
  endtask

  task automatic check_burst_order(input string tag);
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (obs_win[k] !== tile_win[k] || obs_ker[k] !== tile_ker[k]) begin
        errors++;
        $display("FAIL %s burst_order: cycle %0d map=%h, required %h", tag, k, obs_win[k][DW-1:0], tile_win[k][DW-1:0]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ch_ready !== 1'b0 || mac_start !== 1'b0 || res_valid !== 1'b0 || err_timeout !== 1'b0 ||
        mac_feature_map !== '0 || mac_kernel !== '0 || mac_col_index !== '0 ||
        res_data !== '0 || res_col_index !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b start=%b rv=%b err=%b data=%h, required all 0",
               ch_ready, mac_start, res_valid, err_timeout, res_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ch_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ch_ready=%b right at release, required 0", ch_ready);
    end
    @(negedge clk);
    checks++;
    if (ch_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ch_ready=%b one cycle after release, required 1", ch_ready);
    end
  endtask

  task automatic load_uniform(input logic [DW-1:0] v);
    for (int c = 0; c < NCH; c++) begin
      tile_win[c] = rep9(v);
      tile_ker[c] = rep9(v);
    end
    tile_col = DW'($urandom);
  endtask

  task automatic test_nominal();
    int s0;
    load_uniform(16'h03D7);
    mac_lat = 3;
    s0 = start_cnt;
    push_expected();
    send_tile(0);
    recv_result(0);
    checks++;
    if (last_res !== 16'd2120) begin
      errors++;
      $display("FAIL nominal_value: res_data=%0d, required 2120", last_res);
    end
    checks++;
    if (start_cnt - s0 != 1 || obs_col !== tile_col) begin
      errors++;
      $display("FAIL nominal_start: starts=%0d col=%h, required 1 %h", start_cnt - s0, obs_col, tile_col);
    end
    check_burst_order("nominal");
  endtask

  task automatic test_upstream_stalls();
    for (int c = 0; c < NCH; c++) begin
      tile_win[c] = rep9((c == 0) ? 16'h1000 : (c == 1) ? 16'h2000 : (c == 2) ? 16'h0800 : 16'h4000);
      tile_ker[c] = rep9(16'h4000);
    end
    tile_col = DW'($urandom);
    mac_lat  = 5;
    push_expected();
    send_tile(1);
    recv_result(0);
    check_burst_order("stalls");
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < K * K; i++) begin
        tile_win[c][i*DW +: DW] = DW'($urandom);
        tile_ker[c][i*DW +: DW] = DW'($urandom_range(0, 16'h7FFF));
      end
    tile_col = DW'($urandom);
    mac_lat  = 2;
    push_expected();
    send_tile(0);
    recv_result(10);
  endtask

  task automatic test_watchdog();
    int n_err, err_cyc;
    bit rv_seen, ready_after;
    load_uniform(16'h0100);
    mac_respond = 1'b0;
    n_err = 0; err_cyc = -1; rv_seen = 1'b0; ready_after = 1'b0;
    send_tile(0);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (err_cyc >= 0 && cyc == err_cyc + 1) ready_after = (ch_ready === 1'b1);
      if (err_timeout === 1'b1) begin
        n_err++;
        err_cyc = cyc;
      end
      if (res_valid === 1'b1) rv_seen = 1'b1;
    end
    checks++;
    if (n_err != 1) begin
      errors++;
      $display("FAIL watchdog_pulses: err_timeout high %0d cycles, required 1", n_err);
    end
    checks++;
    if (err_cyc != burst_end_cyc + 65) begin
      errors++;
      $display("FAIL watchdog_time: err at %0d cycles past last burst cycle, required 65", err_cyc - burst_end_cyc);
    end
    checks++;
    if (rv_seen || !ready_after) begin
      errors++;
      $display("FAIL watchdog_after: res_valid_seen=%b ch_ready_next=%b, required 0 1", rv_seen, ready_after);
    end
    mac_respond = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    bit bad;
    load_uniform(16'h1234);
    mac_respond = 1'b0;
    send_tile(0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mac_start !== 1'b0 || mac_feature_map !== '0 || mac_kernel !== '0 || mac_col_index !== '0 ||
        res_valid !== 1'b0 || res_data !== '0 || err_timeout !== 1'b0 || ch_ready !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset: start=%b map=%h col=%h rv=%b ready=%b, required all 0",
               mac_start, mac_feature_map[DW-1:0], mac_col_index, res_valid, ch_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || err_timeout !== 1'b0 || ch_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midburst_idle: partial result or lost ready after reset, required idle COLLECT");
    end
    mac_respond = 1'b1;
    load_uniform(16'h03D7);
    push_expected();
    send_tile(0);
    recv_result(0);
    checks++;
    if (last_res !== 16'd2120) begin
      errors++;
      $display("FAIL midburst_retile: res_data=%0d, required 2120", last_res);
    end
  endtask

  task automatic test_spurious_done();
    bit bad;
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || ch_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL spurious_done: res_valid or ch_ready disturbed by done in COLLECT, required 0 1");
    end
    load_uniform(16'h0200);
    mac_lat = 4;
    push_expected();
    send_tile(0);
    recv_result(0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < K * K; i++) begin
          tile_win[c][i*DW +: DW] = DW'($urandom);
          tile_ker[c][i*DW +: DW] = DW'($urandom);
        end
      tile_col = DW'($urandom);
      mac_lat  = $urandom_range(1, 20);
      push_expected();
      send_tile(2);
      recv_result($urandom_range(0, 4));
      check_burst_order("random");
    end
    checks++;
    if (extra_start != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_end: extra starts=%0d leftover expected=%0d, required 0 0", extra_start, exp_q.size());
    end
  endtask

  // ---------------- sequencing / report ----------------
  initial begin
    rst = 1'b1; ch_valid = 1'b0; ch_window = '0; ch_kernel = '0; ch_col_index = '0;
    res_ready = 1'b0; spur_done = 1'b0; last_res = '0;
    test_reset();
    test_nominal();
    test_upstream_stalls();
    test_backpressure();
    test_watchdog();
    test_reset_mid_burst();
    test_spurious_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench timeout");
  end

endmodule
